// File: rtl/wb_pipelined_mem_slave_if.sv
// Wishbone B4 pipelined bus bundle shared by masters and the memory responder.
// Request signals flow master -> slave; stall/ack/rdata flow slave -> master.
interface wb_pipelined_mem_slave_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output cyc, stb, we, addr, sel, wdata,
        input  stall, ack, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, sel, wdata,
        output stall, ack, rdata
    );
endinterface

// File: rtl/wb_pipelined_mem_slave.sv
// Pipelined Wishbone B4 responder backed by a synchronous-read word RAM.
// One request per cycle, in-order acks after a fixed LATENCY, optional
// periodic stall injection to exercise master-side stall handling.
module wb_pipelined_mem_slave #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_PERIOD = 0,
    parameter string       INIT_FILE    = "",
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    wb_pipelined_mem_slave_if.slave        wb_if
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Parameter sanity: reject configurations the pipeline cannot honour.
    if (STALL_PERIOD == 1) begin : g_bad_stall_period
        $error("wb_pipelined_mem_slave: STALL_PERIOD=1 is illegal (use 0 or >=2)");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("wb_pipelined_mem_slave: LATENCY must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("wb_pipelined_mem_slave: DEPTH must be a power of 2 and >= 2");
    end

    logic              stall_int;
    logic              accept;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rd_data_reg;
    logic [31:0]       mem [DEPTH];
    logic              out_valid;
    logic              out_we;
    logic [31:0]       out_data;

    assign accept   = wb_if.cyc & wb_if.stb & ~stall_int;
    // Byte offset from the window base; the RAM wraps on its own index width.
    assign offset   = wb_if.addr - BASE_ADDR;
    assign word_idx = offset[IDX_W+1:2];

    // Byte lanes and out-of-range upper bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{offset[1:0], offset[31:IDX_W+2]};

    // RAM port: byte-gated write and registered read, both on the accept edge.
    // Contents are not reset so a reset keeps the loaded program/data image.
    always_ff @(posedge clk_i) begin
        if (accept && wb_if.we) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_if.sel[b]) begin
                    mem[word_idx][8*b +: 8] <= wb_if.wdata[8*b +: 8];
                end
            end
        end
        if (accept && !wb_if.we) begin
            rd_data_reg <= mem[word_idx];
        end
    end

    // Response pipeline: stage 0 is loaded on accept and carries the RAM output
    // register as its data; later stages copy the previous one every cycle.
    // Dropping cyc clears every valid bit so an aborted cycle produces no acks.
    genvar gi;
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic        valid_reg;
        logic        we_reg;
        logic [31:0] data;

        if (gi == 0) begin : g_first
            // Capture the accepted request (accept already includes cyc).
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    valid_reg <= 1'b0;
                    we_reg    <= 1'b0;
                end else begin
                    valid_reg <= accept;
                    we_reg    <= wb_if.we;
                end
            end
            assign data = rd_data_reg;
        end else begin : g_shift
            logic [31:0] data_reg;

            // Advance the previous stage unconditionally; abort clears valid.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    valid_reg <= 1'b0;
                    we_reg    <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= wb_if.cyc & g_stage[gi-1].valid_reg;
                    we_reg    <= g_stage[gi-1].we_reg;
                    data_reg  <= g_stage[gi-1].data;
                end
            end
            assign data = data_reg;
        end
    end

    assign out_valid = g_stage[LATENCY-1].valid_reg;
    assign out_we    = g_stage[LATENCY-1].we_reg;
    assign out_data  = g_stage[LATENCY-1].data;

    assign wb_if.ack   = out_valid;
    // Read data is only presented while a read is being acked; otherwise zero.
    assign wb_if.rdata = (out_valid && !out_we) ? out_data : 32'h0;
    assign wb_if.stall = stall_int;

    if (STALL_PERIOD >= 2) begin : g_stall
        localparam int unsigned    CNT_W    = $clog2(STALL_PERIOD);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_PERIOD - 1);

        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;
        logic             stall_reg;

        // Free-running modulo counter, independent of bus activity.
        always_comb begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
            end
        end

        // stall_reg tracks (cnt_reg == CNT_LAST) as a registered output.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                cnt_reg   <= '0;
                stall_reg <= 1'b0;
            end else begin
                cnt_reg   <= cnt_next;
                stall_reg <= (cnt_next == CNT_LAST);
            end
        end

        assign stall_int = stall_reg;
    end else begin : g_no_stall
        assign stall_int = 1'b0;
    end

endmodule

// File: tb/tb_wb_pipelined_mem_slave.sv
// Directed bench for wb_pipelined_mem_slave: four instances with different
// LATENCY/STALL_PERIOD share one stimulus stream; each step checks the instance
// that the step targets against hand-computed values.
module tb_wb_pipelined_mem_slave;

    localparam int          N_DUT = 4;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;

    logic        ack_v   [N_DUT];
    logic        stall_v [N_DUT];
    logic [31:0] rdata_v [N_DUT];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] exp_mem [10];

    wb_pipelined_mem_slave_if bus [N_DUT] ();

    genvar gi;
    for (gi = 0; gi < N_DUT; gi++) begin : g_bus
        assign bus[gi].cyc   = cyc;
        assign bus[gi].stb   = stb;
        assign bus[gi].we    = we;
        assign bus[gi].addr  = addr;
        assign bus[gi].sel   = sel;
        assign bus[gi].wdata = wdata;
        assign ack_v[gi]     = bus[gi].ack;
        assign stall_v[gi]   = bus[gi].stall;
        assign rdata_v[gi]   = bus[gi].rdata;
    end

    // 0: LATENCY=1   1: LATENCY=3   2: LATENCY=2   3: LATENCY=1, STALL_PERIOD=4
    wb_pipelined_mem_slave #(.LATENCY(1)) u_l1 (.clk_i(clk), .rstn_i(rstn), .wb_if(bus[0]));
    wb_pipelined_mem_slave #(.LATENCY(3)) u_l3 (.clk_i(clk), .rstn_i(rstn), .wb_if(bus[1]));
    wb_pipelined_mem_slave #(.LATENCY(2)) u_l2 (.clk_i(clk), .rstn_i(rstn), .wb_if(bus[2]));
    wb_pipelined_mem_slave #(.LATENCY(1), .STALL_PERIOD(4)) u_s4 (.clk_i(clk), .rstn_i(rstn), .wb_if(bus[3]));

    always #5 clk = ~clk;

    // Advance to just after the next rising edge: start of a new bus cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] bs);
        cyc   = c;
        stb   = s;
        we    = w;
        addr  = a;
        wdata = d;
        sel   = bs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Wait (bounded) for a cycle in which the stalling instance is free, so
    // that every instance accepts the request presented in that cycle.
    task automatic wait_no_stall();
        for (int t = 0; t < 8 && stall_v[3]; t++) tick();
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        tick();
        wait_no_stall();
        drive(1'b1, 1'b1, 1'b1, a, d, 4'hF);
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts, acks, stalls, last_stall, pend_word;
        logic pend;

        rstn = 1'b0;
        idle();
        repeat (3) tick();

        // Reset state of every instance
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("rst_ack%0d", i),   32'(ack_v[i]),   32'h0);
            chk($sformatf("rst_stall%0d", i), 32'(stall_v[i]), 32'h0);
            chk($sformatf("rst_rdata%0d", i), rdata_v[i],      32'h0);
        end
        rstn = 1'b1;
        tick();

        // Preload words 0..9 in every instance
        for (int i = 0; i < 10; i++) exp_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        exp_mem[0] = 32'h0000_0013;
        exp_mem[5] = 32'h1122_3344;
        for (int i = 0; i < 10; i++) bus_write(BASE + 32'(4 * i), exp_mem[i]);
        repeat (4) tick();

        // Test 1: LATENCY=1 single read of word 0
        tick();
        drive(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'h0);
        chk("t1_c0_ack", 32'(ack_v[0]), 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
        chk("t1_c1_ack",   32'(ack_v[0]), 32'h1);
        chk("t1_c1_rdata", rdata_v[0],    32'h0000_0013);
        tick();
        chk("t1_c2_ack",   32'(ack_v[0]), 32'h0);
        chk("t1_c2_rdata", rdata_v[0],    32'h0);
        idle();
        repeat (4) tick();

        // Test 2: LATENCY=3 back-to-back reads of words 0..3, acks c3..c6
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k < 4) drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * k), 32'h0, 4'h0);
            else       drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
            chk($sformatf("t2_c%0d_stall", k), 32'(stall_v[1]), 32'h0);
            chk($sformatf("t2_c%0d_ack", k),   32'(ack_v[1]),   32'(k >= 3));
            if (k >= 3) chk($sformatf("t2_c%0d_rdata", k), rdata_v[1], exp_mem[k-3]);
        end
        idle();
        repeat (4) tick();

        // Test 3: partial write then read of word 5
        tick();
        wait_no_stall();
        drive(1'b1, 1'b1, 1'b1, BASE + 32'h14, 32'hDEAD_BEEF, 4'b0101);
        tick();
        drive(1'b1, 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'h0);
        chk("t3_wr_ack",   32'(ack_v[0]), 32'h1);
        chk("t3_wr_rdata", rdata_v[0],    32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
        chk("t3_rd_ack",   32'(ack_v[0]), 32'h1);
        chk("t3_rd_rdata", rdata_v[0],    32'h11AD_33EF);
        exp_mem[5] = 32'h11AD_33EF;
        idle();
        repeat (4) tick();

        // Test 4: STALL_PERIOD=4 streaming reads with address held while stalled
        accepts = 0; acks = 0; stalls = 0; last_stall = -1; pend = 1'b0; pend_word = 0;
        for (int t = 0; t < 40 && (accepts < 10 || pend); t++) begin
            tick();
            chk($sformatf("t4_t%0d_ack", t), 32'(ack_v[3]), 32'(pend));
            if (pend) chk($sformatf("t4_t%0d_rdata", t), rdata_v[3], exp_mem[pend_word]);
            if (ack_v[3]) acks++;
            if (stall_v[3]) begin
                if (last_stall >= 0) chk($sformatf("t4_t%0d_stall_gap", t), 32'(t - last_stall), 32'd4);
                last_stall = t;
                stalls++;
            end
            if (accepts < 10) begin
                drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * accepts), 32'h0, 4'h0);
                pend      = !stall_v[3];
                pend_word = accepts;
                if (!stall_v[3]) accepts++;
            end else begin
                drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
                pend = 1'b0;
            end
        end
        chk("t4_accepts",    32'(accepts),     32'd10);
        chk("t4_acks",       32'(acks),        32'd10);
        chk("t4_stalls_seen", 32'(stalls >= 2), 32'h1);
        idle();
        repeat (4) tick();

        // Test 5: LATENCY=2 abort by dropping cyc, then a fresh read
        tick();
        drive(1'b1, 1'b1, 1'b0, BASE + 32'h4, 32'h0, 4'h0);
        chk("t5_c0_ack", 32'(ack_v[2]), 32'h0);
        tick();
        idle();
        chk("t5_c1_ack", 32'(ack_v[2]), 32'h0);
        tick();
        chk("t5_c2_ack", 32'(ack_v[2]), 32'h0);
        tick();
        chk("t5_c3_ack", 32'(ack_v[2]), 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, BASE + 32'h8, 32'h0, 4'h0);
        chk("t5_c4_ack", 32'(ack_v[2]), 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
        chk("t5_c5_ack", 32'(ack_v[2]), 32'h0);
        tick();
        chk("t5_c6_ack",   32'(ack_v[2]), 32'h1);
        chk("t5_c6_rdata", rdata_v[2],    32'h1202_0202);
        tick();
        chk("t5_c7_ack", 32'(ack_v[2]), 32'h0);
        idle();
        repeat (4) tick();

        // Test 6: asynchronous reset in the middle of a burst
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * k), 32'h0, 4'h0);
        end
        chk("t6_pre_ack", 32'(ack_v[1]), 32'h1);
        #3;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("t6_rst_ack%0d", i),   32'(ack_v[i]),   32'h0);
            chk($sformatf("t6_rst_stall%0d", i), 32'(stall_v[i]), 32'h0);
        end
        idle();
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
            chk($sformatf("t6_post%0d_ack_l3", k), 32'(ack_v[1]),   32'h0);
            chk($sformatf("t6_post%0d_ack_l2", k), 32'(ack_v[2]),   32'h0);
            chk($sformatf("t6_post%0d_stall", k),  32'(stall_v[3]), 32'(k == 2));
        end

        // Address one RAM size past the base wraps to word 0
        tick();
        drive(1'b1, 1'b1, 1'b0, BASE + 32'(4 * 1024), 32'h0, 4'h0);
        tick();
        drive(1'b1, 1'b0, 1'b0, BASE, 32'h0, 4'h0);
        chk("t6_wrap_ack",   32'(ack_v[0]), 32'h1);
        chk("t6_wrap_rdata", rdata_v[0],    32'h0000_0013);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
